pool1_relu: RTL and testbench

2x2/stride-2 max-pooling stage with ReLU for the three 12-bit channels produced by the first convolution layer. Consumes the conv layer's raster stream (24x24 per channel, one pixel per valid cycle) and emits a 12x12 stream per channel to the second convolution buffer. Uses a half-row line buffer per channel, so no frame storage is needed.

---
 rtl/pool1_relu.sv | 138 +++++++++++++
 tb/tb_pool1_relu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool1_relu.sv
// -----------------------------------------------------------------------------
// pool1_relu
//
// 2x2 / stride-2 signed max-pooling for the three channels of the first
// convolution layer, with an optional ReLU on the pooled result. The input is a
// raster stream of WIDTH x HEIGHT pixels, one pixel per valid_in cycle. The
// output is a (WIDTH/2) x (HEIGHT/2) raster stream of pooled results.
//
// Only a half-row line buffer per channel is kept. Even rows leave their
// horizontal pair-maxima in the buffer. Odd rows combine their own pair-maxima
// with the buffered ones to produce one result per 2x2 window.
//
// Build option:
//   POOL1_RELU_EN  defined   -> result = max(window) clamped at 0 (ReLU)
//                  undefined -> result = raw signed max(window)
//
// Ports:
//   clk                       clock, rising edge
//   rst_n                     asynchronous active-low reset
//   valid_in                  one pixel (all three channels) present this cycle
//   conv_out_1..3  [DB-1:0]   signed channel samples, raster order
//   pool_out_1..3  [DB-1:0]   pooled results, held while valid_out_pool=0
//   valid_out_pool            single-cycle pulse per pooled result
// -----------------------------------------------------------------------------
module pool1_relu #(
    parameter int WIDTH     = 24,
    parameter int HEIGHT    = 24,
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] conv_out_1,
    input  logic [DATA_BITS-1:0] conv_out_2,
    input  logic [DATA_BITS-1:0] conv_out_3,
    output logic [DATA_BITS-1:0] pool_out_1,
    output logic [DATA_BITS-1:0] pool_out_2,
    output logic [DATA_BITS-1:0] pool_out_3,
    output logic                 valid_out_pool
);

    localparam int COL_W    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int LB_DEPTH = WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             valid_q;
    logic             last_col;
    logic             last_row;
    logic             emit;
    logic [LB_AW-1:0] lb_idx;

    assign last_col = (col_q == COL_W'(WIDTH - 1));
    assign last_row = (row_q == ROW_W'(HEIGHT - 1));
    // The bottom-right pixel of a window sits in an odd row and an odd column.
    assign emit     = valid_in & row_q[0] & col_q[0];
    assign lb_idx   = LB_AW'(col_q >> 1);

    // Raster position. It advances only on accepted pixels, so gaps anywhere
    // in the frame are invisible to the pooling arithmetic.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= emit;
            if (valid_in) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign valid_out_pool = valid_q;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [DATA_BITS-1:0] sample;
        logic [DATA_BITS-1:0] h_q;
        logic [DATA_BITS-1:0] pool_q;
        logic [DATA_BITS-1:0] lb_q [LB_DEPTH];
        logic [DATA_BITS-1:0] pair_max;
        logic [DATA_BITS-1:0] win_max;
        logic [DATA_BITS-1:0] result;

        assign sample = (c == 0) ? conv_out_1 :
                        (c == 1) ? conv_out_2 : conv_out_3;

        // NOTE: every variable is given a value on every path through this
        // block, so no latch is inferred.
        always_comb begin
            pair_max = ($signed(sample) > $signed(h_q)) ? sample : h_q;
            win_max  = ($signed(lb_q[lb_idx]) > $signed(pair_max)) ?
                       lb_q[lb_idx] : pair_max;
`ifdef POOL1_RELU_EN
            result   = win_max[DATA_BITS-1] ? '0 : win_max;
`else
            result   = win_max;
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                h_q    <= '0;
                pool_q <= '0;
            end else begin
                // The left pixel of each horizontal pair waits for its partner.
                if (valid_in && !col_q[0]) begin
                    h_q <= sample;
                end
                if (emit) begin
                    pool_q <= result;
                end
            end
        end

        // NOTE: the line buffer has no reset. Each entry is written in an
        // even row before the following odd row reads it.
        always_ff @(posedge clk) begin
            if (valid_in && col_q[0] && !row_q[0]) begin
                lb_q[lb_idx] <= pair_max;
            end
        end
    end

    assign pool_out_1 = g_ch[0].pool_q;
    assign pool_out_2 = g_ch[1].pool_q;
    assign pool_out_3 = g_ch[2].pool_q;

endmodule

// File: tb/tb_pool1_relu.sv
// -----------------------------------------------------------------------------
// Testbench for pool1_relu. Full frames are built in bench memory. The expected
// 2x2 window maxima are computed from each frame and queued. Frames are then
// streamed with or without random valid gaps, and every output pulse is
// compared against the head of the queue.
// -----------------------------------------------------------------------------
module tb_pool1_relu;

    localparam int W  = 24;
    localparam int H  = 24;
    localparam int DB = 12;

    typedef struct packed {
        logic [DB-1:0] a;
        logic [DB-1:0] b;
        logic [DB-1:0] c;
    } trio_t;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic [DB-1:0] conv_out_1, conv_out_2, conv_out_3;
    logic [DB-1:0] pool_out_1, pool_out_2, pool_out_3;
    logic          valid_out_pool;

    pool1_relu #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .conv_out_1     (conv_out_1),
        .conv_out_2     (conv_out_2),
        .conv_out_3     (conv_out_3),
        .pool_out_1     (pool_out_1),
        .pool_out_2     (pool_out_2),
        .pool_out_3     (pool_out_3),
        .valid_out_pool (valid_out_pool)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    int     pulses = 0;
    trio_t  exp_q[$];
    trio_t  obs_q[$];
    logic [DB-1:0] img [3][H][W];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DB-1:0] smax(input logic [DB-1:0] x,
                                           input logic [DB-1:0] y);
        return ($signed(x) > $signed(y)) ? x : y;
    endfunction

    function automatic logic [DB-1:0] window(input int ch, input int r,
                                             input int c);
        logic [DB-1:0] m;
        m = smax(smax(img[ch][r][c], img[ch][r][c+1]),
                 smax(img[ch][r+1][c], img[ch][r+1][c+1]));
`ifdef POOL1_RELU_EN
        if (m[DB-1]) m = '0;
`endif
        return m;
    endfunction

    // Queue the results whose bottom-right pixel index is below limit.
    task automatic push_expected(input int limit);
        trio_t t;
        for (int r = 0; r < H; r += 2) begin
            for (int c = 0; c < W; c += 2) begin
                if ((r + 1) * W + c + 1 < limit) begin
                    t.a = window(0, r, c);
                    t.b = window(1, r, c);
                    t.c = window(2, r, c);
                    exp_q.push_back(t);
                end
            end
        end
    endtask

    // Drive pixels [0, limit) of img. Called and returns at posedge + 1.
    task automatic stream(input int limit, input int gap_pct);
        for (int i = 0; i < limit; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                valid_in = 1'b0;
                @(posedge clk); #1;
            end
            valid_in   = 1'b1;
            conv_out_1 = img[0][i / W][i % W];
            conv_out_2 = img[1][i / W][i % W];
            conv_out_3 = img[2][i / W][i % W];
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
    endtask

    task automatic run_frame(input int limit, input int gap_pct);
        push_expected(limit);
        stream(limit, gap_pct);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img[0][r][c] = DB'(r * W + c);
                img[1][r][c] = DB'(-(r * W + c));
                img[2][r][c] = DB'(100);
            end
    endtask

    task automatic fill_pattern(input logic [DB-1:0] tl, input logic [DB-1:0] tr,
                                input logic [DB-1:0] bl, input logic [DB-1:0] br);
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    img[ch][r][c] = (r % 2 == 0) ? ((c % 2 == 0) ? tl : tr)
                                                 : ((c % 2 == 0) ? bl : br);
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    img[ch][r][c] = DB'($urandom);
    endtask

    // Scoreboard side: compare every pulse with the oldest queued result.
    always @(negedge clk) begin
        if (valid_out_pool) begin
            trio_t t;
            pulses++;
            obs_q.push_back({pool_out_1, pool_out_2, pool_out_3});
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                t = exp_q.pop_front();
                check("pool_out_1", 32'(pool_out_1), 32'(t.a));
                check("pool_out_2", 32'(pool_out_2), 32'(t.b));
                check("pool_out_3", 32'(pool_out_3), 32'(t.c));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   p0;
        logic [DB-1:0] neg_exp;
        rst_n      = 1'b1;
        valid_in   = 1'b0;
        conv_out_1 = '0;
        conv_out_2 = '0;
        conv_out_3 = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pool_out_1", 32'(pool_out_1), 32'd0);
        check("rst_pool_out_2", 32'(pool_out_2), 32'd0);
        check("rst_pool_out_3", 32'(pool_out_3), 32'd0);
        check("rst_valid", 32'(valid_out_pool), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp frame, gap-free, distinct per-channel content.
        fill_ramp();
        obs_q.delete();
        p0 = pulses;
        run_frame(W * H, 0);
        settle();
        check("ramp_pulses", 32'(pulses - p0), 32'd144);
        if (obs_q.size() == 144) begin
            check("ramp_first", 32'(obs_q[0].a), 32'd25);
            check("ramp_second", 32'(obs_q[1].a), 32'd27);
            check("ramp_last", 32'(obs_q[143].a), 32'd575);
            check("ramp_ch3", 32'(obs_q[5].c), 32'd100);
        end

        // All-negative windows: ReLU clamps, otherwise the largest is -3.
`ifdef POOL1_RELU_EN
        neg_exp = '0;
`else
        neg_exp = 12'hFFD;
`endif
        fill_pattern(12'hFFB, 12'hFFD, 12'hFF9, 12'hFF7);
        obs_q.delete();
        run_frame(W * H, 0);
        settle();
        check("neg_count", 32'(obs_q.size()), 32'd144);
        if (obs_q.size() > 0) begin
            check("neg_ch1", 32'(obs_q[0].a), 32'(neg_exp));
            check("neg_ch3", 32'(obs_q[0].c), 32'(neg_exp));
        end

        // Extremes: a correct signed compare picks 7FF over 800.
        fill_pattern(12'h800, 12'h7FF, 12'h800, 12'h800);
        obs_q.delete();
        run_frame(W * H, 10);
        settle();
        check("ext_count", 32'(obs_q.size()), 32'd144);
        if (obs_q.size() > 0) begin
            check("ext_ch1", 32'(obs_q[0].a), 32'h7FF);
            check("ext_ch2", 32'(obs_q[0].b), 32'h7FF);
        end

        // Two back-to-back random frames with ~50% valid duty.
        p0 = pulses;
        fill_random();
        run_frame(W * H, 50);
        fill_random();
        run_frame(W * H, 50);
        settle();
        check("b2b_pulses", 32'(pulses - p0), 32'd288);

        // Abort at row 13, col 7, then a fresh full frame.
        fill_random();
        run_frame(13 * W + 7, 30);
        rst_n = 1'b0;
        #1;
        check("abort_pool_out_1", 32'(pool_out_1), 32'd0);
        check("abort_pool_out_2", 32'(pool_out_2), 32'd0);
        check("abort_valid", 32'(valid_out_pool), 32'd0);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        p0 = pulses;
        fill_random();
        run_frame(W * H, 20);
        settle();
        check("post_abort_pulses", 32'(pulses - p0), 32'd144);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
